// File: rtl/inet_checksum_pkg.sv
// Shared types and helpers for the streaming Internet checksum engine.
// Also used by csum_beat_adder and inet_checksum_axis.
package inet_checksum_pkg;

   localparam int unsigned CSUM_W = 16;

   typedef enum logic [1:0] {
      ACCUM,
      FOLD1,
      FOLD2,
      OUT
   } state_t;

   // One end-around-carry fold of a 32-bit partial sum.
   function automatic logic [31:0] fold32(input logic [31:0] a);
      return 32'(a[31:16]) + 32'(a[15:0]);
   endfunction

endpackage

// File: rtl/csum_beat_adder.sv
// Combinational per-beat checksum adder: tkeep byte masking, then a sum of the
// big-endian 16-bit lane-pair words.
module csum_beat_adder
   import inet_checksum_pkg::*;
#(
   parameter int unsigned BYTES = 2,
   parameter int unsigned SUM_W = CSUM_W + $clog2(BYTES / 2) + 1
) (
   input  logic [BYTES-1:0]   tkeep_i,
   input  logic [8*BYTES-1:0] tdata_i,
   output logic [SUM_W-1:0]   beat_sum_o
);

   localparam int unsigned WORDS = BYTES / 2;

   logic [CSUM_W-1:0] words [WORDS];

   // Byte 2k is the high half of word k, so an odd trailing byte pads low.
   always_comb begin
      for (int k = 0; k < WORDS; k++) begin
         words[k] = {tdata_i[16*k +: 8] & {8{tkeep_i[2*k]}},
                     tdata_i[16*k+8 +: 8] & {8{tkeep_i[2*k+1]}}};
      end
   end

   always_comb begin
      beat_sum_o = '0;
      for (int k = 0; k < WORDS; k++) begin
         beat_sum_o = beat_sum_o + SUM_W'(words[k]);
      end
   end

endmodule

// File: rtl/inet_checksum_axis.sv
// Streaming RFC 1071 checksum engine: one 16-bit result beat per input packet.
// Define INET_CHECKSUM_SEED_EN to add the axis_i_seed pseudo-header partial sum.
module inet_checksum_axis
   import inet_checksum_pkg::*;
#(
   parameter int unsigned BYTES        = 2,
   parameter bit          ZERO_TO_FFFF = 1'b1
) (
   input  logic                clk,
   input  logic                sreset,
   output logic                axis_i_tready,
   input  logic                axis_i_tvalid,
   input  logic                axis_i_tlast,
   input  logic [BYTES-1:0]    axis_i_tkeep,
   input  logic [8*BYTES-1:0]  axis_i_tdata,
`ifdef INET_CHECKSUM_SEED_EN
   input  logic [CSUM_W-1:0]   axis_i_seed,
`endif
   input  logic                axis_o_tready,
   output logic                axis_o_tvalid,
   output logic                axis_o_tlast,
   output logic [CSUM_W-1:0]   axis_o_tdata
);

   localparam int unsigned SUM_W = CSUM_W + $clog2(BYTES / 2) + 1;

   state_t            state_q, state_d;
   logic [31:0]       acc_q, acc_d;
   logic [SUM_W-1:0]  beat_sum;
   logic [31:0]       seed_add;
   logic [CSUM_W-1:0] csum;

   csum_beat_adder #(
      .BYTES (BYTES),
      .SUM_W (SUM_W)
   ) u_beat_adder (
      .tkeep_i    (axis_i_tkeep),
      .tdata_i    (axis_i_tdata),
      .beat_sum_o (beat_sum)
   );

`ifdef INET_CHECKSUM_SEED_EN
   logic first_q, first_d;

   // The seed joins the sum only on the first accepted beat of a packet.
   always_comb begin
      seed_add = first_q ? 32'(axis_i_seed) : 32'd0;
      first_d  = first_q;
      if (state_q == ACCUM && axis_i_tvalid) begin
         first_d = 1'b0;
      end else if (state_q == OUT && axis_o_tready) begin
         first_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (sreset) begin
         first_q <= 1'b1;
      end else begin
         first_q <= first_d;
      end
   end
`else
   assign seed_add = 32'd0;
`endif

   assign axis_o_tlast = 1'b1;

   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      axis_i_tready = 1'b0;
      axis_o_tvalid = 1'b0;
      axis_o_tdata  = '0;
      csum          = ~acc_q[15:0];
      if (ZERO_TO_FFFF && csum == '0) begin
         csum = '1;
      end
      case (state_q)
         ACCUM: begin
            axis_i_tready = 1'b1;
            if (axis_i_tvalid) begin
               acc_d = fold32(acc_q) + 32'(beat_sum) + seed_add;
               if (axis_i_tlast) begin
                  state_d = FOLD1;
               end
            end
         end
         FOLD1: begin
            acc_d   = fold32(acc_q);
            state_d = FOLD2;
         end
         FOLD2: begin
            acc_d   = fold32(acc_q);
            state_d = OUT;
         end
         OUT: begin
            axis_o_tvalid = 1'b1;
            axis_o_tdata  = csum;
            if (axis_o_tready) begin
               acc_d   = '0;
               state_d = ACCUM;
            end
         end
         default: begin
            acc_d   = '0;
            state_d = ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (sreset) begin
         state_q <= ACCUM;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
      end
   end

endmodule

// File: tb/tb_inet_checksum_axis.sv
// Self-checking bench for inet_checksum_axis: directed RFC 1071 vectors plus
// randomized packets on a 2-byte and an 8-byte instance against a reference model.
module tb_inet_checksum_axis;

   logic clk = 1'b0;
   logic sreset;
   always #5 clk = ~clk;

   logic        a_itready, a_tvalid, a_tlast, a_otready, a_otvalid, a_otlast;
   logic [1:0]  a_tkeep;
   logic [15:0] a_tdata, a_otdata;
   logic        b_itready, b_tvalid, b_tlast, b_otready, b_otvalid, b_otlast;
   logic [7:0]  b_tkeep;
   logic [63:0] b_tdata;
   logic [15:0] b_otdata;
   logic [15:0] seed;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
   } beat_t;
   beat_t pkt[$];

   inet_checksum_axis #(.BYTES(2), .ZERO_TO_FFFF(1'b1)) u_dut_a (
      .clk           (clk),
      .sreset        (sreset),
      .axis_i_tready (a_itready),
      .axis_i_tvalid (a_tvalid),
      .axis_i_tlast  (a_tlast),
      .axis_i_tkeep  (a_tkeep),
      .axis_i_tdata  (a_tdata),
`ifdef INET_CHECKSUM_SEED_EN
      .axis_i_seed   (seed),
`endif
      .axis_o_tready (a_otready),
      .axis_o_tvalid (a_otvalid),
      .axis_o_tlast  (a_otlast),
      .axis_o_tdata  (a_otdata)
   );

   inet_checksum_axis #(.BYTES(8), .ZERO_TO_FFFF(1'b0)) u_dut_b (
      .clk           (clk),
      .sreset        (sreset),
      .axis_i_tready (b_itready),
      .axis_i_tvalid (b_tvalid),
      .axis_i_tlast  (b_tlast),
      .axis_i_tkeep  (b_tkeep),
      .axis_i_tdata  (b_tdata),
`ifdef INET_CHECKSUM_SEED_EN
      .axis_i_seed   (seed),
`endif
      .axis_o_tready (b_otready),
      .axis_o_tvalid (b_otvalid),
      .axis_o_tlast  (b_otlast),
      .axis_o_tdata  (b_otdata)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference: sum every big-endian byte pair of the packet as plain integers,
   // wrap carries back in, complement, then apply the instance's zero rule.
   function automatic logic [15:0] model(input int sel);
      int          lanes;
      longint      s;
      logic [7:0]  hi, lo;
      logic [15:0] cs;
      lanes = (sel == 0) ? 2 : 8;
      s = 0;
`ifdef INET_CHECKSUM_SEED_EN
      s = longint'(seed);
`endif
      foreach (pkt[j]) begin
         for (int i = 0; i < lanes; i += 2) begin
            hi = pkt[j].keep[i]   ? pkt[j].data[8*i +: 8]     : 8'h00;
            lo = pkt[j].keep[i+1] ? pkt[j].data[8*i+8 +: 8]   : 8'h00;
            s += longint'({hi, lo});
         end
      end
      while (s > 65535) s = (s & 65535) + (s >> 16);
      cs = ~16'(s);
      if (sel == 0 && cs == 16'h0000) cs = 16'hFFFF;
      return cs;
   endfunction

   function automatic logic itready(input int sel);
      return (sel == 0) ? a_itready : b_itready;
   endfunction

   function automatic logic otvalid(input int sel);
      return (sel == 0) ? a_otvalid : b_otvalid;
   endfunction

   function automatic logic [15:0] otdata(input int sel);
      return (sel == 0) ? a_otdata : b_otdata;
   endfunction

   task automatic drive_in(input int sel, input logic v, input logic l,
                           input logic [7:0] k, input logic [63:0] d);
      if (sel == 0) begin
         a_tvalid = v; a_tlast = l; a_tkeep = k[1:0]; a_tdata = d[15:0];
      end else begin
         b_tvalid = v; b_tlast = l; b_tkeep = k; b_tdata = d;
      end
   endtask

   task automatic set_otready(input int sel, input logic v);
      if (sel == 0) a_otready = v;
      else b_otready = v;
   endtask

   task automatic add(input logic [63:0] d, input logic [7:0] k);
      beat_t b;
      b.data = d;
      b.keep = k;
      pkt.push_back(b);
   endtask

   task automatic run_pkt(input int sel, input int stall, input bit gaps, input bit lat,
                          output logic [15:0] got);
      logic [15:0] exp;
      bit          hs;
      int          cyc;
      exp = model(sel);
      got = 16'h0000;
      for (int j = 0; j < pkt.size(); j++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            drive_in(sel, 1'b0, 1'b0, 8'h00, 64'h0);
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
         drive_in(sel, 1'b1, (j == pkt.size() - 1), pkt[j].keep, pkt[j].data);
         hs  = 1'b0;
         cyc = 0;
         while (!hs && cyc < 50) begin
            @(negedge clk);
            hs = itready(sel);
            @(posedge clk);
            #1;
            cyc++;
         end
         if (!hs) begin
            check_eq("in_handshake_timeout", 32'd0, 32'd1);
            drive_in(sel, 1'b0, 1'b0, 8'h00, 64'h0);
            return;
         end
      end
      drive_in(sel, 1'b0, 1'b0, 8'h00, 64'h0);
      if (lat) begin
         check_eq("lat_fold1_valid", otvalid(sel), 1'b0);
         check_eq("lat_fold1_ready", itready(sel), 1'b0);
         @(posedge clk); #1;
         check_eq("lat_fold2_valid", otvalid(sel), 1'b0);
         @(posedge clk); #1;
         check_eq("lat_out_valid", otvalid(sel), 1'b1);
      end else begin
         cyc = 0;
         while (!otvalid(sel) && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
         end
         check_eq("out_valid", otvalid(sel), 1'b1);
      end
      if (!otvalid(sel)) return;
      got = otdata(sel);
      check_eq("csum", got, exp);
      repeat (stall) begin
         @(posedge clk); #1;
         check_eq("hold_valid", otvalid(sel), 1'b1);
         check_eq("hold_data", otdata(sel), got);
         check_eq("hold_in_ready", itready(sel), 1'b0);
      end
      set_otready(sel, 1'b1);
      @(posedge clk); #1;
      set_otready(sel, 1'b0);
      check_eq("post_valid", otvalid(sel), 1'b0);
      check_eq("post_in_ready", itready(sel), 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [15:0] got;
      a_tvalid = 0; a_tlast = 0; a_tkeep = '0; a_tdata = '0; a_otready = 0;
      b_tvalid = 0; b_tlast = 0; b_tkeep = '0; b_tdata = '0; b_otready = 0;
      seed   = 16'h0000;
      sreset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_a_valid", a_otvalid, 1'b0);
      check_eq("rst_a_data", a_otdata, 16'h0000);
      check_eq("rst_a_in_ready", a_itready, 1'b1);
      check_eq("rst_a_tlast", a_otlast, 1'b1);
      check_eq("rst_b_valid", b_otvalid, 1'b0);
      check_eq("rst_b_in_ready", b_itready, 1'b1);
      sreset = 1'b0;

      // RFC 1071 example, 2-byte beats with exact latency.
      pkt = {};
      add(64'h0100, 8'h03); add(64'h03F2, 8'h03); add(64'hF5F4, 8'h03); add(64'hF7F6, 8'h03);
      run_pkt(0, 0, 0, 1, got);
      check_eq("rfc_a", got, 16'h220D);

      pkt = {};
      add(64'hF7F6F5F4_03F20100, 8'hFF);
      run_pkt(1, 0, 0, 1, got);
      check_eq("rfc_b", got, 16'h220D);

      // Odd length; the masked byte carries garbage that must not count.
      pkt = {};
      add(64'h3412, 8'h03); add(64'hAB56, 8'h01);
      run_pkt(0, 0, 0, 0, got);
      check_eq("odd_len", got, 16'h97CB);

      pkt = {};
      add(64'hFFFF, 8'h03); add(64'h0100, 8'h03);
      run_pkt(0, 0, 0, 0, got);
      check_eq("end_around", got, 16'hFFFE);

      pkt = {};
      add(64'hFFFF, 8'h03);
      run_pkt(0, 0, 0, 0, got);
      check_eq("zero_to_ffff", got, 16'hFFFF);

      pkt = {};
      add(64'hDEADBEEF_1234FFFF, 8'h03);
      run_pkt(1, 0, 0, 0, got);
      check_eq("zero_kept", got, 16'h0000);

      // Output stall of 10 cycles.
      pkt = {};
      add(64'h0100, 8'h03); add(64'h03F2, 8'h03); add(64'hF5F4, 8'h03); add(64'hF7F6, 8'h03);
      run_pkt(0, 10, 0, 0, got);
      check_eq("stall_rfc", got, 16'h220D);

      // Reset in the middle of a packet.
      a_tvalid = 1; a_tlast = 0; a_tkeep = 2'b11; a_tdata = 16'h1357;
      @(posedge clk); #1;
      a_tdata = 16'h9BDF;
      @(posedge clk); #1;
      a_tvalid = 0;
      sreset   = 1'b1;
      @(posedge clk); #1;
      sreset   = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         check_eq("rst_mid_no_out", a_otvalid, 1'b0);
      end
      pkt = {};
      add(64'h3412, 8'h03); add(64'h0056, 8'h01);
      run_pkt(0, 0, 0, 0, got);
      check_eq("after_rst", got, 16'h97CB);

`ifdef INET_CHECKSUM_SEED_EN
      seed = 16'h0011;
      for (int r = 0; r < 2; r++) begin
         pkt = {};
         add(64'h0100, 8'h03);
         run_pkt(0, 0, 0, 0, got);
         check_eq("seed_pkt", got, 16'hFFED);
      end
`endif

      for (int i = 0; i < 60; i++) begin
         int sel;
         int nb;
         sel = i % 2;
         nb  = $urandom_range(1, 6);
         pkt = {};
         for (int j = 0; j < nb; j++) begin
            logic [7:0] k;
            k = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            add({$urandom(), $urandom()}, k);
         end
`ifdef INET_CHECKSUM_SEED_EN
         seed = 16'($urandom());
`endif
         run_pkt(sel, $urandom_range(0, 3), 1'b1, 1'b0, got);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
